// File: rtl/router_output_ctrl_if.sv
// Arbitrator-side and link-side signals of one router output port.
// The controller takes the slave view.
interface router_output_ctrl_if #(
  parameter int DATA_W = 64
);
  logic              polarity;
  logic              arb_en_even;
  logic              arb_en_odd;
  logic              out_empty_even;
  logic              out_empty_odd;
  logic              wr_en_even;
  logic [DATA_W-1:0] wr_data_even;
  logic              wr_en_odd;
  logic [DATA_W-1:0] wr_data_odd;
  logic              ri;
  logic              so;
  logic [DATA_W-1:0] data_o;

  modport master (
    output wr_en_even, wr_data_even,
    output wr_en_odd, wr_data_odd,
    output ri,
    input  polarity, arb_en_even, arb_en_odd,
    input  out_empty_even, out_empty_odd,
    input  so, data_o
  );

  modport slave (
    input  wr_en_even, wr_data_even,
    input  wr_en_odd, wr_data_odd,
    input  ri,
    output polarity, arb_en_even, arb_en_odd,
    output out_empty_even, out_empty_odd,
    output so, data_o
  );
endinterface

// File: rtl/router_output_ctrl.sv
// Output-port controller: one VC arbitrates into its buffer while
// the other VC drains onto the link; phases swap every run cycle.
module router_output_ctrl #(
  parameter int DATA_W = 64,
  parameter int VC_BIT = 63,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  router_output_ctrl_if.slave bus,
  output logic [CNT_W-1:0] tx_count,
  output logic             err
);
  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_e;

  phase_e            pol_q, pol_d;
  logic              full_even_q, full_even_d;
  logic              full_odd_q, full_odd_d;
  logic [DATA_W-1:0] buf_even_q, buf_even_d;
  logic [DATA_W-1:0] buf_odd_q, buf_odd_d;
  logic              so_q, so_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic int_even, int_odd;
  logic wr_ok_even, wr_ok_odd;
  logic send_even, send_odd;

  always_comb begin
    pol_d       = pol_q;
    full_even_d = full_even_q;
    full_odd_d  = full_odd_q;
    buf_even_d  = buf_even_q;
    buf_odd_d   = buf_odd_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    err_d       = err_q;

    int_even = run & (pol_q == PH_EVEN);
    int_odd  = run & (pol_q == PH_ODD);

    wr_ok_even = bus.wr_en_even & int_even & ~full_even_q
               & ~bus.wr_data_even[VC_BIT];
    wr_ok_odd  = bus.wr_en_odd & int_odd & ~full_odd_q
               & bus.wr_data_odd[VC_BIT];

    // the link VC is whichever one is not arbitrating
    send_even = int_odd & full_even_q & bus.ri;
    send_odd  = int_even & full_odd_q & bus.ri;
    so_d      = send_even | send_odd;

    if (run) pol_d = phase_e'(~pol_q);

    if ((bus.wr_en_even & ~wr_ok_even) |
        (bus.wr_en_odd & ~wr_ok_odd))
      err_d = 1'b1;

    if (wr_ok_even) begin
      full_even_d = 1'b1;
      buf_even_d  = bus.wr_data_even;
    end
    if (wr_ok_odd) begin
      full_odd_d = 1'b1;
      buf_odd_d  = bus.wr_data_odd;
    end

    unique case (1'b1)
      send_even: begin
        data_d      = buf_even_q;
        full_even_d = 1'b0;
      end
      send_odd: begin
        data_d     = buf_odd_q;
        full_odd_d = 1'b0;
      end
      default: data_d = data_q;
    endcase

    if (so_d && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pol_q       <= PH_EVEN;
      full_even_q <= 1'b0;
      full_odd_q  <= 1'b0;
      buf_even_q  <= '0;
      buf_odd_q   <= '0;
      so_q        <= 1'b0;
      data_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      pol_q       <= pol_d;
      full_even_q <= full_even_d;
      full_odd_q  <= full_odd_d;
      buf_even_q  <= buf_even_d;
      buf_odd_q   <= buf_odd_d;
      so_q        <= so_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign bus.polarity       = (pol_q == PH_ODD);
  assign bus.arb_en_even    = run & (pol_q == PH_EVEN);
  assign bus.arb_en_odd     = run & (pol_q == PH_ODD);
  assign bus.out_empty_even = ~full_even_q;
  assign bus.out_empty_odd  = ~full_odd_q;
  assign bus.so             = so_q;
  assign bus.data_o         = data_q;
  assign tx_count           = cnt_q;
  assign err                = err_q;
endmodule

// File: tb/tb_router_output_ctrl.sv
// Scoreboard bench for router_output_ctrl with a per-VC reference
// model; a small counter width exercises saturation.
module tb_router_output_ctrl;
  localparam int DW = 64;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [CW-1:0] tx_count;
  logic          err;

  router_output_ctrl_if #(.DATA_W(DW)) bus ();

  router_output_ctrl #(
    .DATA_W(DW),
    .VC_BIT(63),
    .CNT_W (CW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .bus     (bus),
    .tx_count(tx_count),
    .err     (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: index 0 = even VC, 1 = odd VC
  bit            m_pol;
  bit            m_full[2];
  logic [DW-1:0] m_buf[2];
  bit            m_so;
  logic [DW-1:0] m_data;
  bit            m_err;
  int            m_cnt;
  logic [DW-1:0] exp_q[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void m_reset();
    m_pol = 0;
    m_full[0] = 0;
    m_full[1] = 0;
    m_buf[0] = '0;
    m_buf[1] = '0;
    m_so = 0;
    m_data = '0;
    m_err = 0;
    m_cnt = 0;
    exp_q.delete();
  endfunction

  function automatic void m_write(int v, bit en, logic [DW-1:0] d);
    if (!en) return;
    if (run && v == int'(m_pol) && !m_full[v] && d[63] == v[0]) begin
      m_full[v] = 1;
      m_buf[v] = d;
    end else begin
      m_err = 1;
    end
  endfunction

  function automatic void m_step();
    int l;
    m_write(0, bus.wr_en_even, bus.wr_data_even);
    m_write(1, bus.wr_en_odd, bus.wr_data_odd);
    if (!run) begin
      m_so = 0;
      return;
    end
    l = m_pol ? 0 : 1;
    m_so = 0;
    if (m_full[l] && bus.ri) begin
      m_full[l] = 0;
      m_so = 1;
      m_data = m_buf[l];
      exp_q.push_back(m_buf[l]);
      if (m_cnt < CMAX) m_cnt++;
    end
    m_pol = !m_pol;
  endfunction

  always @(posedge clk) if (reset) m_step();

  // monitor: compares DUT state and pops the scoreboard on each flit
  always @(negedge clk) begin
    if (reset) begin
      check("polarity", bus.polarity, m_pol);
      check("empty_even", bus.out_empty_even, !m_full[0]);
      check("empty_odd", bus.out_empty_odd, !m_full[1]);
      check("arb_en_even", bus.arb_en_even, run & !m_pol);
      check("arb_en_odd", bus.arb_en_odd, run & m_pol);
      check("so", bus.so, m_so);
      check("err", err, m_err);
      check("tx_count", tx_count, m_cnt);
      check("data_hold", bus.data_o, m_data);
      if (bus.so) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL so_unexpected: got so=1 data %h expected no flit",
                   bus.data_o);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (bus.data_o !== e) begin
            fails++;
            $display("FAIL data_o: got %h expected %h", bus.data_o, e);
          end
        end
      end
    end
  end

  task automatic drive(bit r, bit we, logic [DW-1:0] de,
                       bit wo, logic [DW-1:0] dod, bit rdy);
    run = r;
    bus.wr_en_even = we;
    bus.wr_data_even = de;
    bus.wr_en_odd = wo;
    bus.wr_data_odd = dod;
    bus.ri = rdy;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) drive(1, 0, '0, 0, '0, rdy);
  endtask

  task automatic align(bit p, bit rdy);
    for (int i = 0; i < 3 && m_pol != p; i++) idle(1, rdy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0;
    run = 0;
    bus.wr_en_even = 0;
    bus.wr_data_even = '0;
    bus.wr_en_odd = 0;
    bus.wr_data_odd = '0;
    bus.ri = 0;
    m_reset();
    #3;
    check("rst_polarity", bus.polarity, 0);
    check("rst_so", bus.so, 0);
    check("rst_empty_even", bus.out_empty_even, 1);
    check("rst_tx", tx_count, 0);
    #20 reset = 1;
    @(negedge clk);
    #1;

    idle(4, 0);

    // even flit, straight through
    align(0, 1);
    drive(1, 1, 64'h0000_0000_0000_00AB, 0, '0, 1);
    idle(3, 1);

    // odd flit held back by ri=0
    align(1, 0);
    drive(1, 0, '0, 1, 64'h8000_0000_0000_00CD, 0);
    idle(6, 0);
    idle(3, 1);

    // write into full buffer, bad tag, link-phase write
    align(0, 0);
    drive(1, 1, 64'h11, 0, '0, 0);
    idle(1, 0);
    drive(1, 1, 64'h22, 0, '0, 0);
    idle(3, 1);
    align(0, 1);
    drive(1, 1, 64'h8000_0000_0000_0033, 0, '0, 1);
    drive(1, 1, 64'h44, 0, '0, 1);
    idle(3, 1);

    // both buffers full, run low with ri high
    align(0, 0);
    drive(1, 1, 64'h55, 0, '0, 0);
    drive(1, 0, '0, 1, 64'h8000_0000_0000_0066, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, '0, 0, '0, 1);
    idle(4, 1);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [DW-1:0] de, dod;
      de = {$urandom, $urandom};
      dod = {$urandom, $urandom};
      de[63] = ($urandom_range(0, 9) == 0);
      dod[63] = ($urandom_range(0, 9) != 0);
      drive($urandom_range(0, 7) != 0,
            $urandom_range(0, 2) == 0, de,
            $urandom_range(0, 2) == 0, dod,
            $urandom_range(0, 1) == 1);
    end
    idle(4, 1);

    // asynchronous reset with both buffers full
    align(0, 0);
    drive(1, 1, 64'h77, 0, '0, 0);
    drive(1, 0, '0, 1, 64'h8000_0000_0000_0088, 0);
    drive(1, 1, 64'h8000_0000_0000_0099, 0, '0, 1);
    #2;
    reset = 0;
    #1;
    check("arst_so", bus.so, 0);
    check("arst_data", bus.data_o, 64'h0);
    check("arst_empty_even", bus.out_empty_even, 1);
    check("arst_empty_odd", bus.out_empty_odd, 1);
    check("arst_tx", tx_count, 0);
    check("arst_err", err, 0);
    check("arst_pol", bus.polarity, 0);
    m_reset();
    #3;
    reset = 1;
    @(negedge clk);
    #1;

    for (int i = 0; i < 60; i++) begin
      logic [DW-1:0] de, dod;
      de = {$urandom, $urandom};
      dod = {$urandom, $urandom};
      de[63] = 0;
      dod[63] = 1;
      drive(1, $urandom_range(0, 1) == 1, de,
            $urandom_range(0, 1) == 1, dod,
            $urandom_range(0, 3) != 0);
    end
    idle(4, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/router_output_ctrl.md
Name: router_output_ctrl

Overview:
- Per-output-port controller for one router output (UP, DOWN, LEFT, RIGHT or PE) that owns the even and odd virtual-channel output buffers.
- Generates the router polarity and the per-VC arbitrator enables: one VC arbitrates internally while the other VC drains onto the link.
- Exposes per-VC empty flags to the arbitrators, accepts their buffer writes, and drives the so/ri link handshake toward the neighbour router or PE.

Parameters:
- DATA_W, 64, flit width.
- VC_BIT, 63, bit index of the VC tag inside a flit (0 = even, 1 = odd).
- CNT_W, 16, width of the saturating transmitted-flit counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset.
- run  input  1  scheduler enable; low freezes polarity and all transfers.
- polarity  output  1  current phase; 0 = even VC internal / odd VC link, 1 = odd VC internal / even VC link.
- arb_en_even  output  1  enable to even-VC arbitrator = run & ~polarity.
- arb_en_odd  output  1  enable to odd-VC arbitrator = run & polarity.
- out_empty_even  output  1  even buffer empty (= ~full_even).
- out_empty_odd  output  1  odd buffer empty (= ~full_odd).
- wr_en_even  input  1  write strobe from even arbitrator.
- wr_data_even  input  DATA_W  flit from even arbitrator.
- wr_en_odd  input  1  write strobe from odd arbitrator.
- wr_data_odd  input  DATA_W  flit from odd arbitrator.
- ri  input  1  receiver ready for the link-phase VC.
- so  output  1  send strobe, flit valid on data_o this cycle.
- data_o  output  DATA_W  link flit.
- tx_count  output  CNT_W  flits sent on link, saturating.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async, reset=0) values: polarity=0, full_even=0, full_odd=0, so=0, data_o=0, tx_count=0, err=0. Combinational outputs follow: out_empty_*=1, arb_en_even=run, arb_en_odd=0.
- Phase: on each edge with run=1, polarity toggles. With run=0, polarity holds, no write or send occurs, and so<=0.
- Internal VC is even when polarity=0 and odd when polarity=1. The link VC is the other one.
- Buffer write, internal VC only, at the edge:
  - If wr_en_v=1, full_v=0 and wr_data_v[VC_BIT] matches v: buf_v<=wr_data_v and full_v<=1. out_empty_v falls the next cycle.
  - wr_en_v=1 while full_v=1: write ignored, buffer unchanged, err<=1.
  - wr_en_v=1 with a wrong VC tag: write ignored, err<=1.
  - wr_en_v=1 for the link-phase VC or while run=0: write ignored, err<=1.
- Link send, link VC only, at the edge with run=1:
  - If full_link=1 and ri=1: so<=1, data_o<=buf_link, full_link<=0, tx_count<=tx_count+1 (saturating at all ones).
  - Otherwise so<=0 and data_o holds its previous value.
  - so and data_o are registered, so a flit appears the cycle after the send edge, with polarity already toggled.
- Write and send never target the same VC in one cycle because of phase separation. Both VCs can change state on the same edge.
- Latency: a flit written at edge N, where the internal VC is v, is eligible to send at edge N+1, where the link VC is v. With ri=1 it reaches data_o/so in the cycle after edge N+1.
- ri=0: the buffer stays full and is retried on every later link phase for that VC. Flits are never dropped.
- err stays set until reset. tx_count holds at its maximum.
- Reset asserted mid-operation immediately clears both buffers, so and err. In-flight flits are discarded.

Test Plan:
- Reset then run=1: polarity toggles 0,1,0,...; arb_en_even/arb_en_odd alternate; out_empty_even=out_empty_odd=1; so=0.
- polarity=0, wr_en_even=1, wr_data_even=64'h0000_0000_0000_00AB, ri=1: out_empty_even=0 next cycle. One cycle later so=1 and data_o=64'h...00AB; then out_empty_even=1 and tx_count=1.
- Write odd flit with bit63=1 while ri=0 for 6 cycles, then ri=1: so stays 0 and the buffer stays full. so=1 with the correct data follows the first odd link phase that has ri=1, exactly once.
- Write even buffer while full_even=1, or with wr_data_even[63]=1: buffer unchanged, err=1 and stays 1. No extra flit appears on the link.
- run=0 for 4 cycles with both buffers full and ri=1: polarity frozen, so=0, tx_count unchanged. After run=1, both buffers drain on consecutive link phases and tx_count increases by 2.
- Both buffers full, assert reset mid-run: so=0, data_o=0, out_empty_*=1, tx_count=0 and err=0 asynchronously, before the next clock edge.
